hc595_rx: RTL

Receive-side counterpart of the board's 74HC595 display-chain driver. It oversamples the three-wire serial interface (`sh_cp`, `st_cp`, `ds`) in the system clock domain and rebuilds each latched 16-bit word as a parallel value. It splits that word into the `{marker, seg, sel}` fields used by the 8-digit display path. It serves as a bus monitor and self-check point on the display chain, and as the loopback checker in display-path benches.

---
 rtl/hc595_rx_if.sv | 28 ++
 rtl/hc595_rx.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/hc595_rx_if.sv
// Bundle of the three-wire 74HC595 serial lines plus the rebuilt-word outputs of the receiver.
// The master drives the serial lines and enable; the slave (receiver) drives the decoded results.
interface hc595_rx_if #(
   parameter int WIDTH = 16
);
   logic             en;
   logic             sh_cp;
   logic             st_cp;
   logic             ds;
   logic [WIDTH-1:0] data;
   logic             marker;
   logic [6:0]       seg;
   logic [7:0]       sel;
   logic             data_valid;
   logic             frame_err;
   logic             timeout_err;
   logic [15:0]      frame_cnt;

   modport master (
      output en, sh_cp, st_cp, ds,
      input  data, marker, seg, sel, data_valid, frame_err, timeout_err, frame_cnt
   );

   modport slave (
      input  en, sh_cp, st_cp, ds,
      output data, marker, seg, sel, data_valid, frame_err, timeout_err, frame_cnt
   );
endinterface

// File: rtl/hc595_rx.sv
// Oversampling receiver for a 74HC595 display chain: rebuilds each latched word and
// splits it into marker/segment/select fields, flagging short, long and stalled frames.
module hc595_rx #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic        clk,
   input  logic        reset,
   hc595_rx_if.slave   bus
);

   localparam int CNT_W  = $clog2(WIDTH + 2);
   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   localparam int WARM_W = $clog2(SYNC_STAGES + 2);

   localparam logic [CNT_W-1:0]  BITS_FULL = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0]  BITS_SAT  = CNT_W'(WIDTH + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
   localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] shSync_q, shSync_d;
   logic [SYNC_STAGES-1:0] stSync_q, stSync_d;
   logic [SYNC_STAGES-1:0] dsSync_q, dsSync_d;
   logic                   shHist_q, stHist_q;
   logic [WARM_W-1:0]      warm_q, warm_d;
   logic [WIDTH-1:0]       shreg_q, shreg_d;
   logic [CNT_W-1:0]       bitCnt_q, bitCnt_d;
   logic [IDLE_W-1:0]      idle_q, idle_d;
   logic [WIDTH-1:0]       data_q, data_d;
   logic                   marker_q, marker_d;
   logic [6:0]             seg_q, seg_d;
   logic [7:0]             sel_q, sel_d;
   logic                   dataValid_q, dataValid_d;
   logic                   frameErr_q, frameErr_d;
   logic                   timeoutErr_q, timeoutErr_d;
   logic [15:0]            frameCnt_q, frameCnt_d;

   logic shLevel, stLevel, dsLevel;
   logic shEv, stEv;

   assign shLevel = shSync_q[SYNC_STAGES-1];
   assign stLevel = stSync_q[SYNC_STAGES-1];
   assign dsLevel = dsSync_q[SYNC_STAGES-1];

   // Edges are ignored until the synchronizers and history flops have filled after reset,
   // so a line that was already high when reset dropped is never mistaken for a rise.
   assign shEv = bus.en && (warm_q == '0) && shLevel && !shHist_q;
   assign stEv = bus.en && (warm_q == '0) && stLevel && !stHist_q;

   // Next-state logic: a latch and a shift in the same cycle both happen, with the latch
   // capturing the pre-shift register and the new bit opening the next frame.
   always_comb begin
      shSync_d     = {shSync_q[SYNC_STAGES-2:0], bus.sh_cp};
      stSync_d     = {stSync_q[SYNC_STAGES-2:0], bus.st_cp};
      dsSync_d     = {dsSync_q[SYNC_STAGES-2:0], bus.ds};
      warm_d       = (warm_q != '0) ? warm_q - WARM_W'(1) : warm_q;
      shreg_d      = shreg_q;
      bitCnt_d     = bitCnt_q;
      idle_d       = idle_q;
      data_d       = data_q;
      marker_d     = marker_q;
      seg_d        = seg_q;
      sel_d        = sel_q;
      dataValid_d  = 1'b0;
      frameErr_d   = 1'b0;
      timeoutErr_d = 1'b0;
      frameCnt_d   = frameCnt_q;

      if (!bus.en) begin
         idle_d = '0;
      end else begin
         if (stEv) begin
            data_d      = shreg_q;
            marker_d    = shreg_q[15];
            seg_d       = shreg_q[14:8];
            sel_d       = shreg_q[7:0];
            dataValid_d = 1'b1;
            frameErr_d  = (bitCnt_q != BITS_FULL);
            frameCnt_d  = frameCnt_q + 16'd1;
            bitCnt_d    = '0;
            idle_d      = '0;
         end
         if (shEv) begin
            shreg_d = {shreg_q[WIDTH-2:0], dsLevel};
            if (stEv)
               bitCnt_d = CNT_W'(1);
            else if (bitCnt_q != BITS_SAT)
               bitCnt_d = bitCnt_q + CNT_W'(1);
            idle_d = '0;
         end else if (!stEv && bitCnt_q != '0) begin
            if (idle_q == IDLE_LAST) begin
               bitCnt_d     = '0;
               idle_d       = '0;
               timeoutErr_d = 1'b1;
            end else begin
               idle_d = idle_q + IDLE_W'(1);
            end
         end
      end
   end

   // State and output registers; everything clears on reset except the warm-up counter,
   // which reloads so edge detection restarts cleanly.
   always_ff @(posedge clk) begin
      if (reset) begin
         shSync_q     <= '0;
         stSync_q     <= '0;
         dsSync_q     <= '0;
         shHist_q     <= 1'b0;
         stHist_q     <= 1'b0;
         warm_q       <= WARM_INIT;
         shreg_q      <= '0;
         bitCnt_q     <= '0;
         idle_q       <= '0;
         data_q       <= '0;
         marker_q     <= 1'b0;
         seg_q        <= '0;
         sel_q        <= '0;
         dataValid_q  <= 1'b0;
         frameErr_q   <= 1'b0;
         timeoutErr_q <= 1'b0;
         frameCnt_q   <= '0;
      end else begin
         shSync_q     <= shSync_d;
         stSync_q     <= stSync_d;
         dsSync_q     <= dsSync_d;
         shHist_q     <= shLevel;
         stHist_q     <= stLevel;
         warm_q       <= warm_d;
         shreg_q      <= shreg_d;
         bitCnt_q     <= bitCnt_d;
         idle_q       <= idle_d;
         data_q       <= data_d;
         marker_q     <= marker_d;
         seg_q        <= seg_d;
         sel_q        <= sel_d;
         dataValid_q  <= dataValid_d;
         frameErr_q   <= frameErr_d;
         timeoutErr_q <= timeoutErr_d;
         frameCnt_q   <= frameCnt_d;
      end
   end

   assign bus.data        = data_q;
   assign bus.marker      = marker_q;
   assign bus.seg         = seg_q;
   assign bus.sel         = sel_q;
   assign bus.data_valid  = dataValid_q;
   assign bus.frame_err   = frameErr_q;
   assign bus.timeout_err = timeoutErr_q;
   assign bus.frame_cnt   = frameCnt_q;

endmodule
